// File: rtl/rhd_reg_cfg_sequencer.sv
// RHD2000 register-configuration sequencer: walks the per-chip parameter RAM,
// emits register-write commands, then an optional CALIBRATE plus dummy reads.
module rhd_reg_cfg_sequencer #(
  parameter int unsigned NUM_REGS = 14,
  parameter int unsigned REG_BASE = 0,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned N_DUMMY  = 9
) (
  input  logic        clk_A,
  input  logic        reset,
  input  logic        start,
  input  logic        calib_en,
  output logic [9:0]  RAM_addr_B,
  input  logic [15:0] RAM_data_out_B,
  output logic [15:0] cmd_word,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        busy,
  output logic        done,
  output logic [4:0]  cmd_count
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_ISSUE = 3'd1;
  localparam logic [2:0] RD_WAIT  = 3'd2;
  localparam logic [2:0] SEND     = 3'd3;
  localparam logic [2:0] CAL      = 3'd4;
  localparam logic [2:0] DUMMY    = 3'd5;
  localparam logic [2:0] FIN      = 3'd6;

  localparam logic [15:0] CMD_CALIBRATE = 16'h5500;
  localparam logic [15:0] CMD_DUMMY     = 16'hE800;

  logic [2:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  lat_q, lat_d;
  logic [7:0]  dcnt_q, dcnt_d;
  logic        cal_q, cal_d;
  logic [15:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        accept, last_entry, adv;
  logic [5:0]  reg_idx;
  logic        unused_data;

  assign accept      = valid_q & cmd_ready;
  assign last_entry  = (idx_q == 4'(NUM_REGS - 1));
  assign reg_idx     = 6'(REG_BASE + idx_q);
  assign unused_data = ^RAM_data_out_B[14:8];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    dcnt_d  = dcnt_q;
    cal_d   = cal_q;
    word_d  = word_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    adv     = 1'b0;

    if (accept && cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          cnt_d   = '0;
          cal_d   = calib_en;
          state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        lat_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_q == 2'(RD_LAT - 1)) begin
          if (RAM_data_out_B[15]) begin
            adv = 1'b1;
          end else begin
            word_d  = {2'b10, reg_idx, RAM_data_out_B[7:0]};
            valid_d = 1'b1;
            state_d = SEND;
          end
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      SEND: begin
        if (accept) begin
          valid_d = 1'b0;
          adv     = 1'b1;
        end
      end
      CAL: begin
        if (accept) begin
          if (N_DUMMY == 0) begin
            valid_d = 1'b0;
            state_d = FIN;
          end else begin
            dcnt_d  = '0;
            word_d  = CMD_DUMMY;
            state_d = DUMMY;
          end
        end
      end
      DUMMY: begin
        if (accept) begin
          if (dcnt_q == 8'(N_DUMMY - 1)) begin
            valid_d = 1'b0;
            state_d = FIN;
          end else begin
            dcnt_d = dcnt_q + 8'd1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Shared by skipped entries and accepted writes; CALIBRATE follows with no gap.
    if (adv) begin
      if (!last_entry) begin
        idx_d   = idx_q + 4'd1;
        state_d = RD_ISSUE;
      end else if (cal_q) begin
        word_d  = CMD_CALIBRATE;
        valid_d = 1'b1;
        state_d = CAL;
      end else begin
        state_d = FIN;
      end
    end
  end

  always_ff @(posedge clk_A or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lat_q   <= '0;
      dcnt_q  <= '0;
      cal_q   <= 1'b0;
      word_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      dcnt_q  <= dcnt_d;
      cal_q   <= cal_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign RAM_addr_B = {6'b0, idx_q};
  assign cmd_word   = word_q;
  assign cmd_valid  = valid_q;
  assign busy       = (state_q != IDLE) && (state_q != FIN);
  assign done       = (state_q == FIN);
  assign cmd_count  = cnt_q;

endmodule
